// File: rtl/stream_shuffler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_shuffler_pkg
//  Description : Shared width helpers and the identity-control generator used
//                by the streaming lane shuffler and its interface.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_shuffler_pkg;

    // Upper bound on the packed control bus produced by identity_ctrl()
    localparam int MAX_CTRL_BITS = 4096;

    // Ceiling log2; c_log_2(1) = 0, c_log_2(12) = 4, c_log_2(16) = 4
    function automatic int c_log_2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // Per-lane index width, never narrower than one bit
    function automatic int ctrl_width(input int n);
        return (c_log_2(n) < 1) ? 1 : c_log_2(n);
    endfunction

    // Packed data bus width
    function automatic int shuffle_data_width(input int dw, input int n);
        return dw * n;
    endfunction

    // Packed control bus width
    function automatic int shuffle_ctrl_width(input int n);
        return ctrl_width(n) * n;
    endfunction

    // Control word where output lane i selects source lane i
    function automatic logic [MAX_CTRL_BITS-1:0] identity_ctrl(input int n, input int cw);
        logic [MAX_CTRL_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < cw; b++) begin
                if ((i * cw + b) < MAX_CTRL_BITS) begin
                    r[i * cw + b] = ((i >> b) & 1) != 0;
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_shuffler_if.sv
`default_nettype none
// ============================================================================
//  Module      : stream_shuffler_if
//  Description : Input and output valid/ready streams of the lane shuffler.
//                The shuffler takes the slave view; its environment the master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface stream_shuffler_if
    import stream_shuffler_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DATA   = 16
);
    localparam int DBUS = shuffle_data_width(DATA_WIDTH, NUM_DATA);
    localparam int CBUS = shuffle_ctrl_width(NUM_DATA);

    logic            IN_VALID;
    logic            IN_READY;
    logic [DBUS-1:0] IN_DATA;
    logic [CBUS-1:0] IN_CTRL;
    logic [NUM_DATA-1:0] IN_MASK;
    logic            IN_LAST;
    logic            OUT_VALID;
    logic            OUT_READY;
    logic [DBUS-1:0] OUT_DATA;
    logic            OUT_LAST;

    modport slave (
        input  IN_VALID, IN_DATA, IN_CTRL, IN_MASK, IN_LAST, OUT_READY,
        output IN_READY, OUT_VALID, OUT_DATA, OUT_LAST
    );

    modport master (
        output IN_VALID, IN_DATA, IN_CTRL, IN_MASK, IN_LAST, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_DATA, OUT_LAST
    );

endinterface
`default_nettype wire

// File: rtl/stream_shuffler_lane_mux.sv
`default_nettype none
// ============================================================================
//  Module      : stream_shuffler_lane_mux
//  Description : One output lane: picks a source lane by index, zeroes it when
//                masked or when the index names a lane that does not exist.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_shuffler_lane_mux
    import stream_shuffler_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DATA   = 16,
    parameter int CTRL_WIDTH = 4
) (
    input  wire logic [DATA_WIDTH*NUM_DATA-1:0] data_i,
    input  wire logic [CTRL_WIDTH-1:0]          idx_i,
    input  wire logic                           mask_i,
    output logic      [DATA_WIDTH-1:0]          lane_o
);

    // Decode the index against existing lanes only, so out-of-range yields zero
    always_comb begin
        lane_o = '0;
        if (!mask_i) begin
            for (int j = 0; j < NUM_DATA; j++) begin
                if (idx_i == CTRL_WIDTH'(j)) begin
                    lane_o = data_i[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_shuffler.sv
`default_nettype none
// ============================================================================
//  Module      : stream_shuffler
//  Description : Streaming lane permuter with per-lane zero masking, static or
//                per-beat control, 1- or 2-stage pipeline, valid/ready on both
//                sides and a per-packet beat counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_shuffler
    import stream_shuffler_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_DATA    = 16,
    parameter int PIPE_STAGES = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  wire logic                                    ACLK,
    input  wire logic                                    ARESETN,
    stream_shuffler_if.slave                             bus,
    input  wire logic                                    CFG_WR_EN,
    input  wire logic [shuffle_ctrl_width(NUM_DATA)-1:0] CFG_CTRL,
    input  wire logic [NUM_DATA-1:0]                     CFG_MASK,
    input  wire logic                                    CFG_STATIC_EN,
    output logic      [COUNT_WIDTH-1:0]                  BEAT_COUNT,
    output logic                                         PKT_DONE
);

    localparam int CTRL_WIDTH = ctrl_width(NUM_DATA);
    localparam int DBUS       = shuffle_data_width(DATA_WIDTH, NUM_DATA);
    localparam int CBUS       = shuffle_ctrl_width(NUM_DATA);
    localparam logic [MAX_CTRL_BITS-1:0] C_ID_FULL = identity_ctrl(NUM_DATA, CTRL_WIDTH);
    localparam logic [CBUS-1:0]          C_IDENTITY = C_ID_FULL[CBUS-1:0];

    logic [CBUS-1:0]        static_ctrl_q;
    logic [NUM_DATA-1:0]    static_mask_q;
    logic                   s0_valid_q;
    logic [DBUS-1:0]        s0_data_q;
    logic [CBUS-1:0]        s0_ctrl_q;
    logic [NUM_DATA-1:0]    s0_mask_q;
    logic                   s0_last_q;
    logic [COUNT_WIDTH-1:0] beat_count_q, beat_count_d;
    logic                   pkt_done_q, pkt_done_d;

    logic                   w_advance;
    logic                   w_out_valid;
    logic                   w_out_last;
    logic [DBUS-1:0]        w_out_data;
    logic [DBUS-1:0]        w_mux_data;
    logic [CBUS-1:0]        w_eff_ctrl;
    logic [NUM_DATA-1:0]    w_eff_mask;
    logic                   w_xfer;

    // Whole pipe moves together whenever the output slot is empty or draining
    assign w_advance    = !w_out_valid || bus.OUT_READY;
    assign bus.IN_READY = w_advance;
    assign w_eff_ctrl   = CFG_STATIC_EN ? static_ctrl_q : bus.IN_CTRL;
    assign w_eff_mask   = CFG_STATIC_EN ? static_mask_q : bus.IN_MASK;
    assign w_xfer       = w_out_valid && bus.OUT_READY;

    // Static control registers; a beat accepted on the write edge still sees the old values
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            static_ctrl_q <= C_IDENTITY;
            static_mask_q <= '0;
        end else if (CFG_WR_EN) begin
            static_ctrl_q <= CFG_CTRL;
            static_mask_q <= CFG_MASK;
        end
    end

    // Stage 0 captures the beat together with the control that applies to it
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            s0_valid_q <= 1'b0;
            s0_data_q  <= '0;
            s0_ctrl_q  <= C_IDENTITY;
            s0_mask_q  <= '0;
            s0_last_q  <= 1'b0;
        end else if (w_advance) begin
            s0_valid_q <= bus.IN_VALID;
            if (bus.IN_VALID) begin
                s0_data_q <= bus.IN_DATA;
                s0_ctrl_q <= w_eff_ctrl;
                s0_mask_q <= w_eff_mask;
                s0_last_q <= bus.IN_LAST;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_DATA; gi++) begin : g_lane
        stream_shuffler_lane_mux #(
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_DATA   (NUM_DATA),
            .CTRL_WIDTH (CTRL_WIDTH)
        ) u_lane_mux (
            .data_i (s0_data_q),
            .idx_i  (s0_ctrl_q[gi*CTRL_WIDTH +: CTRL_WIDTH]),
            .mask_i (s0_mask_q[gi]),
            .lane_o (w_mux_data[gi*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Any PIPE_STAGES other than 1 builds the registered-mux variant
    if (PIPE_STAGES == 1) begin : g_pipe1
        assign w_out_valid = s0_valid_q;
        assign w_out_data  = w_mux_data;
        assign w_out_last  = s0_last_q;
    end else begin : g_pipe2
        logic            s1_valid_q;
        logic [DBUS-1:0] s1_data_q;
        logic            s1_last_q;

        // Output register holds the shuffled beat until downstream takes it
        always_ff @(posedge ACLK) begin
            if (!ARESETN) begin
                s1_valid_q <= 1'b0;
                s1_data_q  <= '0;
                s1_last_q  <= 1'b0;
            end else if (w_advance) begin
                s1_valid_q <= s0_valid_q;
                if (s0_valid_q) begin
                    s1_data_q <= w_mux_data;
                    s1_last_q <= s0_last_q;
                end
            end
        end

        assign w_out_valid = s1_valid_q;
        assign w_out_data  = s1_data_q;
        assign w_out_last  = s1_last_q;
    end

    assign bus.OUT_VALID = w_out_valid;
    assign bus.OUT_DATA  = w_out_data;
    assign bus.OUT_LAST  = w_out_last;

    // Next beat count: bump per transfer, clear and flag completion on the last beat
    always_comb begin
        beat_count_d = beat_count_q;
        pkt_done_d   = 1'b0;
        if (w_xfer) begin
            if (w_out_last) begin
                beat_count_d = '0;
                pkt_done_d   = 1'b1;
            end else begin
                beat_count_d = beat_count_q + COUNT_WIDTH'(1);
            end
        end
    end

    // Beat counter and packet-done pulse registers
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            beat_count_q <= '0;
            pkt_done_q   <= 1'b0;
        end else begin
            beat_count_q <= beat_count_d;
            pkt_done_q   <= pkt_done_d;
        end
    end

    assign BEAT_COUNT = beat_count_q;
    assign PKT_DONE   = pkt_done_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_shuffler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_shuffler
//  Description : Scoreboard bench: a 16-lane 2-stage shuffler and a 12-lane
//                1-stage shuffler driven with directed beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_shuffler;
    import stream_shuffler_pkg::*;

    localparam int DW = 16;
    localparam int N  = 16;
    localparam int N2 = 12;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int pulses = 0;

    stream_shuffler_if #(.DATA_WIDTH(DW), .NUM_DATA(N))  b16 ();
    stream_shuffler_if #(.DATA_WIDTH(DW), .NUM_DATA(N2)) b12 ();

    logic            cfg_wr = 1'b0;
    logic            cfg_static = 1'b0;
    logic [N*CW-1:0] cfg_ctrl = '0;
    logic [N-1:0]    cfg_mask = '0;
    logic [15:0]     cnt16, cnt12;
    logic            done16, done12;

    stream_shuffler #(.DATA_WIDTH(DW), .NUM_DATA(N), .PIPE_STAGES(2), .COUNT_WIDTH(16)) dut (
        .ACLK(clk), .ARESETN(rst_n), .bus(b16),
        .CFG_WR_EN(cfg_wr), .CFG_CTRL(cfg_ctrl), .CFG_MASK(cfg_mask), .CFG_STATIC_EN(cfg_static),
        .BEAT_COUNT(cnt16), .PKT_DONE(done16)
    );

    stream_shuffler #(.DATA_WIDTH(DW), .NUM_DATA(N2), .PIPE_STAGES(1), .COUNT_WIDTH(16)) dut12 (
        .ACLK(clk), .ARESETN(rst_n), .bus(b12),
        .CFG_WR_EN(1'b0), .CFG_CTRL(48'h0), .CFG_MASK(12'h0), .CFG_STATIC_EN(1'b0),
        .BEAT_COUNT(cnt12), .PKT_DONE(done12)
    );

    typedef struct { logic [255:0] d; logic l; } exp16_t;
    typedef struct { logic [191:0] d; logic l; } exp12_t;
    exp16_t q16[$];
    exp12_t q12[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    logic         stall_prev = 1'b0;
    logic [255:0] stall_data = '0;
    logic         stall_last = 1'b0;
    logic [15:0]  m_cnt = '0;
    logic         m_done = 1'b0;

    always @(negedge clk) begin
        exp16_t e;
        if (!rst_n) begin
            stall_prev = 1'b0;
            m_cnt      = '0;
            m_done     = 1'b0;
        end else begin
            chk("beat_count16", cnt16, m_cnt);
            chk("pkt_done16", done16, m_done);
            if (done16) pulses++;
            if (stall_prev) begin
                chk("stall_valid16", b16.OUT_VALID, 1'b1);
                chk("stall_data16", b16.OUT_DATA, stall_data);
                chk("stall_last16", b16.OUT_LAST, stall_last);
            end
            if (b16.OUT_VALID && !b16.OUT_READY) chk("stall_in_ready16", b16.IN_READY, 1'b0);
            stall_prev = b16.OUT_VALID && !b16.OUT_READY;
            stall_data = b16.OUT_DATA;
            stall_last = b16.OUT_LAST;
            m_done = 1'b0;
            if (b16.OUT_VALID && b16.OUT_READY) begin
                if (q16.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_beat16: actual beat %h, required no beat", b16.OUT_DATA);
                end else begin
                    e = q16.pop_front();
                    chk("out_data16", b16.OUT_DATA, e.d);
                    chk("out_last16", b16.OUT_LAST, e.l);
                end
                if (b16.OUT_LAST) begin
                    m_cnt  = '0;
                    m_done = 1'b1;
                end else begin
                    m_cnt = m_cnt + 16'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        exp12_t e;
        if (rst_n && b12.OUT_VALID && b12.OUT_READY) begin
            if (q12.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_beat12: actual beat %h, required no beat", b12.OUT_DATA);
            end else begin
                e = q12.pop_front();
                chk("out_data12", {64'h0, b12.OUT_DATA}, {64'h0, e.d});
                chk("out_last12", b12.OUT_LAST, e.l);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send16(input logic [255:0] d, input logic [63:0] c, input logic [15:0] m,
                          input logic lst, input logic [255:0] e);
        int waitc;
        waitc = 0;
        b16.IN_VALID = 1'b1; b16.IN_DATA = d; b16.IN_CTRL = c; b16.IN_MASK = m; b16.IN_LAST = lst;
        @(negedge clk);
        while (!b16.IN_READY && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        checks++;
        if (!b16.IN_READY) begin
            fails++;
            $display("FAIL accept16: IN_READY actual 0 after %0d cycles, required 1", waitc);
        end else begin
            q16.push_back('{d: e, l: lst});
        end
        @(posedge clk); #1;
        b16.IN_VALID = 1'b0;
    endtask

    task automatic send12(input logic [191:0] d, input logic [47:0] c, input logic [11:0] m,
                          input logic lst, input logic [191:0] e);
        int waitc;
        waitc = 0;
        b12.IN_VALID = 1'b1; b12.IN_DATA = d; b12.IN_CTRL = c; b12.IN_MASK = m; b12.IN_LAST = lst;
        @(negedge clk);
        while (!b12.IN_READY && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        checks++;
        if (!b12.IN_READY) begin
            fails++;
            $display("FAIL accept12: IN_READY actual 0 after %0d cycles, required 1", waitc);
        end else begin
            q12.push_back('{d: e, l: lst});
        end
        @(posedge clk); #1;
        b12.IN_VALID = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q16.size() != 0 || q12.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q16.size() != 0 || q12.size() != 0) begin
            fails++;
            $display("FAIL %s: actual %0d/%0d beats outstanding, required 0", name, q16.size(), q12.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q16.delete();
        q12.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [255:0] d_id, e_rev, e_bc, e_bcast5, d_k;
    logic [63:0]  c_rev, c_bc7, c_all5;
    logic [191:0] d12, e12a, e12b;
    logic [47:0]  c12a, c12b;
    int           p0;

    initial begin
        b16.IN_VALID = 1'b0; b16.IN_DATA = '0; b16.IN_CTRL = '0; b16.IN_MASK = '0;
        b16.IN_LAST = 1'b0; b16.OUT_READY = 1'b0;
        b12.IN_VALID = 1'b0; b12.IN_DATA = '0; b12.IN_CTRL = '0; b12.IN_MASK = '0;
        b12.IN_LAST = 1'b0; b12.OUT_READY = 1'b1;

        for (int i = 0; i < N; i++) begin
            d_id[i*16 +: 16]   = 16'h1000 + 16'(i);
            c_rev[i*4 +: 4]    = 4'(15 - i);
            c_bc7[i*4 +: 4]    = 4'd7;
            c_all5[i*4 +: 4]   = 4'd5;
            e_rev[i*16 +: 16]  = (i == 0) ? 16'h0000 : 16'h1000 + 16'(15 - i);
            e_bc[i*16 +: 16]   = ((16'hF0F0 >> i) & 16'h1) != 0 ? 16'h0000 : 16'h1007;
            e_bcast5[i*16 +: 16] = 16'h1005;
        end

        // Reset state
        do_reset();
        @(negedge clk);
        chk("reset_out_valid", b16.OUT_VALID, 1'b0);
        chk("reset_out_data", b16.OUT_DATA, 256'h0);
        chk("reset_out_last", b16.OUT_LAST, 1'b0);
        chk("reset_in_ready", b16.IN_READY, 1'b1);
        chk("reset_out_valid12", b12.OUT_VALID, 1'b0);
        @(posedge clk); #1;

        // Identity from reset in static mode; per-beat fields would zero everything
        cfg_static = 1'b1;
        b16.OUT_READY = 1'b1;
        send16(d_id, 64'h0, 16'hFFFF, 1'b0, d_id);
        @(negedge clk);
        chk("latency2_not_yet", b16.OUT_VALID, 1'b0);
        @(negedge clk);
        chk("latency2_valid", b16.OUT_VALID, 1'b1);
        drain("drain_identity");

        // Per-beat reverse with lane 0 masked, then per-beat broadcast of lane 7 under a mask
        cfg_static = 1'b0;
        send16(d_id, c_rev, 16'h0001, 1'b0, e_rev);
        send16(d_id, c_bc7, 16'hF0F0, 1'b0, e_bc);
        drain("drain_reverse");

        // Backpressure: eight beats with OUT_READY low across four edges
        cfg_static = 1'b1;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    for (int i = 0; i < N; i++) d_k[i*16 +: 16] = 16'h2000 + 16'(k * 256 + i);
                    send16(d_k, 64'h0, 16'h0, 1'b0, d_k);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 b16.OUT_READY = 1'b0;
                repeat (4) @(posedge clk);
                #1 b16.OUT_READY = 1'b1;
            end
        join
        drain("drain_backpressure");

        // Config write on the accept edge: that beat keeps identity, the next is broadcast 5
        cfg_ctrl = c_all5;
        cfg_mask = '0;
        cfg_wr = 1'b1;
        send16(d_id, 64'h0, 16'h0, 1'b0, d_id);
        cfg_wr = 1'b0;
        send16(d_id, 64'h0, 16'h0, 1'b0, e_bcast5);
        drain("drain_cfg");

        // Packet of four beats, last on the fourth
        do_reset();
        p0 = pulses;
        for (int k = 0; k < 4; k++) send16(d_id, 64'h0, 16'h0, (k == 3), d_id);
        drain("drain_packet");
        repeat (3) @(negedge clk);
        chk("packet_count_cleared", cnt16, 16'd0);
        chk("pkt_done_pulses", 32'(pulses - p0), 32'd1);
        @(posedge clk); #1;

        // Reset with two beats in flight
        send16(d_id, 64'h0, 16'h0, 1'b0, d_id);
        send16(d_id, 64'h0, 16'h0, 1'b0, d_id);
        rst_n = 1'b0;
        q16.delete();
        q12.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midreset_out_valid", b16.OUT_VALID, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_reset_no_stale", b16.OUT_VALID, 1'b0);
        end
        @(posedge clk); #1;

        // 12 lanes, single stage: index 13 on lane 2, then reverse with index 15 on lane 5
        for (int i = 0; i < N2; i++) begin
            d12[i*16 +: 16]  = 16'h3000 + 16'(i);
            c12a[i*4 +: 4]   = (i == 2) ? 4'd13 : 4'(i);
            e12a[i*16 +: 16] = (i == 2) ? 16'h0000 : 16'h3000 + 16'(i);
            c12b[i*4 +: 4]   = (i == 5) ? 4'd15 : 4'(11 - i);
            e12b[i*16 +: 16] = (i == 0 || i == 5) ? 16'h0000 : 16'h3000 + 16'(11 - i);
        end
        send12(d12, c12a, 12'h000, 1'b0, e12a);
        @(negedge clk);
        chk("latency1_valid12", b12.OUT_VALID, 1'b1);
        @(posedge clk); #1;
        send12(d12, c12b, 12'h001, 1'b0, e12b);
        drain("drain_12");
        @(negedge clk);
        chk("beat_count12", cnt12, 16'd2);
        chk("pkt_done12", done12, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/stream_shuffler.md
Name: stream_shuffler

Overview:
- Streaming successor to the single-shot lane shuffler.
- Permutes NUM_DATA lanes of DATA_WIDTH each under per-lane select indices, with per-lane zero-masking.
- Supports static (register-held) or per-beat control, and has a parametrised pipeline depth.
- Uses valid/ready handshakes on both sides so it drops between the read-data path and the PE input FIFOs without external enables.
- Counts beats per packet.

Parameters:
- DATA_WIDTH, 16, bits per lane
- NUM_DATA, 16, lane count (need not be a power of two)
- PIPE_STAGES, 2, register stages from accept to output; legal values 1 or 2
- COUNT_WIDTH, 16, width of the per-packet beat counter

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset; one clock; reset is synchronous and active-low
- IN_VALID  in  1  input beat valid
- IN_READY  out  1  input beat accepted when IN_VALID && IN_READY
- IN_DATA  in  DATA_WIDTH*NUM_DATA  lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- IN_CTRL  in  CTRL_WIDTH*NUM_DATA  per-beat source index for output lane i; CTRL_WIDTH = C_LOG_2(NUM_DATA)
- IN_MASK  in  NUM_DATA  per-beat mask; bit i = 1 forces output lane i to zero
- IN_LAST  in  1  last beat of packet
- CFG_WR_EN  in  1  load static control registers
- CFG_CTRL  in  CTRL_WIDTH*NUM_DATA  static indices
- CFG_MASK  in  NUM_DATA  static mask
- CFG_STATIC_EN  in  1  1 = use static ctrl/mask, 0 = use IN_CTRL/IN_MASK; sampled per beat at accept
- OUT_VALID  out  1  output beat valid
- OUT_READY  in  1  downstream ready
- OUT_DATA  out  DATA_WIDTH*NUM_DATA  shuffled lanes
- OUT_LAST  out  1  IN_LAST delayed with its beat
- BEAT_COUNT  out  COUNT_WIDTH  beats transferred in the current packet
- PKT_DONE  out  1  one-cycle pulse when an OUT_LAST beat transfers

Behaviour:
- Reset (ARESETN low at posedge):
  - all stage valids = 0; OUT_VALID = 0; OUT_DATA = 0; OUT_LAST = 0.
  - BEAT_COUNT = 0; PKT_DONE = 0.
  - static ctrl = identity (lane i selects i); static mask = 0.
- Reset mid-stream discards all in-flight beats; none emerge after reset release.
- Pipeline advance: advance = !OUT_VALID || OUT_READY.
  - IN_READY = advance (combinational). The whole pipe stalls together and holds its contents.
- Stage 0 (on accept) registers:
  - data;
  - the effective ctrl/mask, selected by CFG_STATIC_EN in the same cycle;
  - last.
- Mux, lane i: out_i = mask_i ? 0 : (idx_i < NUM_DATA ? data[idx_i] : 0).
  - Out-of-range index gives zero; this only happens when NUM_DATA is not a power of two.
  - Broadcast (several lanes selecting the same source) is legal.
- Latency:
  - PIPE_STAGES=1: mux is combinational after stage 0; OUT_DATA is the mux output. Latency 1 cycle.
  - PIPE_STAGES=2: mux output is registered. Latency 2 cycles.
- Throughput: 1 beat/cycle while OUT_READY is held high.
- Output stability: OUT_DATA and OUT_LAST stay stable while OUT_VALID && !OUT_READY.
- Config writes:
  - CFG_WR_EN updates the static registers at the clock edge.
  - A beat accepted in the same cycle as CFG_WR_EN uses the old values.
  - Beats already in flight are never affected.
- Beat counter:
  - On a transfer (OUT_VALID && OUT_READY): BEAT_COUNT += 1, wrapping at 2^COUNT_WIDTH with no saturation.
  - If the transferred beat has OUT_LAST: BEAT_COUNT <= 0 and PKT_DONE = 1 for the next cycle.
- Bubbles: IN_VALID low while advance is high moves a bubble in; OUT_VALID drops when the bubble reaches the output.

Decomposition:
- shuffle_pkg (shared, for include), containing:
  - C_LOG_2-based CTRL_WIDTH;
  - SHUFFLE_DATA_WIDTH and SHUFFLE_CTRL_WIDTH derivations;
  - identity-control generator function for reset.
- Sub-module shuffle_lane_mux: one output lane, covering index select, mask and out-of-range zeroing. Instantiated NUM_DATA times in a generate loop.
- Pipeline registers use the existing register module, with wrEn = advance.

Test Plan:
- Reset to identity:
  - Stimulus: reset, then CFG_STATIC_EN=1; send lanes 0..15 with values 0x1000+i, OUT_READY=1.
  - Response: after PIPE_STAGES cycles, OUT_DATA lane i = 0x1000+i.
- Per-beat reverse with mask:
  - Stimulus: IN_CTRL lane i = 15-i, IN_MASK=0x0001.
  - Response: lane 0 = 0, lane i = 0x1000+(15-i) for i≥1.
- Backpressure:
  - Stimulus: stream 8 beats; hold OUT_READY=0 for cycles 3-6.
  - Response: IN_READY=0 during the stall; OUT_DATA frozen; all 8 beats delivered in order, none duplicated or dropped.
- Static config timing:
  - Stimulus: CFG_WR_EN with broadcast (all lanes select 5) on the same cycle a beat is accepted.
  - Response: that beat uses identity; the next beat outputs 0x1005 on every lane.
- Packet counting:
  - Stimulus: send 4 beats, IN_LAST on the 4th.
  - Response: BEAT_COUNT reads 1,2,3, then 0 after the 4th transfer; PKT_DONE pulses exactly once.
- Non-power-of-two and reset mid-flight:
  - Stimulus 1: NUM_DATA=12, index 13 on lane 2.
  - Response 1: lane 2 = 0.
  - Stimulus 2: assert ARESETN low with 2 beats in flight.
  - Response 2: OUT_VALID=0 next cycle and no stale beat afterwards.
